shapool_job_loader: RTL and testbench

//  Upstream stage of the hasher pool. Receives a job as a byte stream (valid/ready) from the host link.

---
 rtl/shapool_job_loader_pkg.sv | 33 +++
 rtl/shapool_loader_timeout.sv | 32 +++
 rtl/shapool_job_loader.sv | 213 +++++++++++++++++++++
 tb/tb_shapool_job_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shapool_job_loader_pkg.sv
// Shared definitions for the hasher-pool job loader: field widths, frame
// length, loader state encoding and the running checksum helper.
// The frame grows by one checksum byte when SHAPOOL_LOADER_CHECKSUM_EN is defined.
package shapool_job_loader_pkg;

  localparam int SHA_STATE_W   = 256;
  localparam int MSG_HEAD_W    = 96;
  localparam int NONCE_START_W = 8;
  localparam int FRAME_BYTES   = 45;

  // Payload bits held in the shadow register (sha_state | message_head | nonce_start).
  localparam int DATA_W = SHA_STATE_W + MSG_HEAD_W + NONCE_START_W;

`ifdef SHAPOOL_LOADER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_BYTES + 1;
`else
  localparam int FRAME_LEN = FRAME_BYTES;
`endif

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    LDR_IDLE   = 2'd0,
    LDR_LOAD   = 2'd1,
    LDR_COMMIT = 2'd2
  } ldr_state_e;

  // Running XOR of the payload bytes; the checksum byte must equal the final value.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/shapool_loader_timeout.sv
// Idle-gap watchdog for a partially received job frame.
// Counts enabled cycles; clear has priority. expired is asserted during the
// LIMIT-th consecutive enabled, uncleared cycle, so a clear in that same cycle wins.
module shapool_loader_timeout #(
  parameter int LIMIT = 4096,
  parameter int W     = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count_r;

  // Idle counter: cleared by reset or clear, advances while enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && !clear && (count_r == W'(LIMIT - 1));

endmodule

// File: rtl/shapool_job_loader.sv
// Hasher-pool job loader: assembles a byte-serial job frame (MSB first) in a
// shadow register and commits sha_state/message_head/nonce_start atomically.
// The pool is held in reset from the first byte of a frame until a good commit.
// Optional feature macro: SHAPOOL_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module shapool_job_loader
  import shapool_job_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [SHA_STATE_W-1:0]   sha_state,
  output logic [MSG_HEAD_W-1:0]    message_head,
  output logic [NONCE_START_W-1:0] nonce_start,
  output logic                     pool_reset,
  output logic                     job_loaded,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_checksum
);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_BYTES = CNT_W'(FRAME_BYTES);

  ldr_state_e        state_r;
  ldr_state_e        next_state_s;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] shadow_r;
  logic              take_s;
  logic              last_s;
  logic              timeout_s;
  logic              commit_ok_s;

  assign take_s = rx_valid && rx_ready;
  assign last_s = (state_r == LDR_LOAD) && take_s && (count_r == LAST_IDX);

  // Idle watchdog exists only when a limit is configured.
  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      shapool_loader_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMEOUT_W)
      ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (take_s || (state_r != LDR_LOAD)),
        .enable  (state_r == LDR_LOAD),
        .expired (timeout_s)
      );
    end else begin : g_no_timeout
      assign timeout_s = 1'b0;
    end
  endgenerate

  // Next-state logic; a byte accepted on the limit cycle suppresses the timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LDR_IDLE: begin
        if (take_s) begin
          next_state_s = LDR_LOAD;
        end else begin
          next_state_s = LDR_IDLE;
        end
      end
      LDR_LOAD: begin
        if (last_s) begin
          next_state_s = LDR_COMMIT;
        end else if (timeout_s) begin
          next_state_s = LDR_IDLE;
        end else begin
          next_state_s = LDR_LOAD;
        end
      end
      LDR_COMMIT: begin
        next_state_s = LDR_IDLE;
      end
      default: begin
        next_state_s = LDR_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LDR_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Byte counter (saturating at the last index) and MSB-first shadow shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r  <= '0;
      shadow_r <= '0;
    end else begin
      case (state_r)
        LDR_IDLE: begin
          if (take_s) begin
            count_r  <= CNT_W'(1);
            shadow_r <= {{(DATA_W - 8){1'b0}}, rx_data};
          end else begin
            count_r  <= '0;
            shadow_r <= shadow_r;
          end
        end
        LDR_LOAD: begin
          if (take_s) begin
            count_r <= (count_r == LAST_IDX) ? count_r : count_r + CNT_W'(1);
            if (count_r < DATA_BYTES) begin
              shadow_r <= {shadow_r[DATA_W-9:0], rx_data};
            end else begin
              shadow_r <= shadow_r;
            end
          end else if (timeout_s) begin
            count_r  <= '0;
            shadow_r <= '0;
          end else begin
            count_r  <= count_r;
            shadow_r <= shadow_r;
          end
        end
        LDR_COMMIT: begin
          count_r  <= '0;
          shadow_r <= shadow_r;
        end
        default: begin
          count_r  <= '0;
          shadow_r <= '0;
        end
      endcase
    end
  end

`ifdef SHAPOOL_LOADER_CHECKSUM_EN
  logic [7:0] xor_r;
  logic       bad_r;

  // Running payload XOR; the trailing byte is compared against it and a
  // mismatch pulses err_checksum during the COMMIT cycle and blocks the commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_r        <= 8'h00;
      bad_r        <= 1'b0;
      err_checksum <= 1'b0;
    end else begin
      err_checksum <= 1'b0;
      if ((state_r == LDR_IDLE) && take_s) begin
        xor_r <= rx_data;
        bad_r <= 1'b0;
      end else if (last_s) begin
        xor_r        <= xor_r;
        bad_r        <= (rx_data != xor_r);
        err_checksum <= (rx_data != xor_r);
      end else if ((state_r == LDR_LOAD) && take_s) begin
        xor_r <= xor_fold(xor_r, rx_data);
        bad_r <= bad_r;
      end else begin
        xor_r <= xor_r;
        bad_r <= bad_r;
      end
    end
  end

  assign commit_ok_s = (state_r == LDR_COMMIT) && !bad_r;
`else
  assign err_checksum = 1'b0;
  assign commit_ok_s  = (state_r == LDR_COMMIT);
`endif

  // Registered outputs: job fields change only on a good commit; pool_reset is
  // raised by the first byte of a frame and dropped only by a good commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sha_state    <= '0;
      message_head <= '0;
      nonce_start  <= '0;
      pool_reset   <= 1'b1;
      job_loaded   <= 1'b0;
      err_timeout  <= 1'b0;
      busy         <= 1'b0;
      rx_ready     <= 1'b0;
    end else begin
      job_loaded  <= commit_ok_s;
      err_timeout <= timeout_s;
      busy        <= (next_state_s == LDR_LOAD) || (next_state_s == LDR_COMMIT);
      rx_ready    <= (next_state_s != LDR_COMMIT);
      if (commit_ok_s) begin
        sha_state    <= shadow_r[DATA_W-1 -: SHA_STATE_W];
        message_head <= shadow_r[MSG_HEAD_W+NONCE_START_W-1 -: MSG_HEAD_W];
        nonce_start  <= shadow_r[NONCE_START_W-1:0];
        pool_reset   <= 1'b0;
      end else if ((state_r == LDR_IDLE) && take_s) begin
        sha_state    <= sha_state;
        message_head <= message_head;
        nonce_start  <= nonce_start;
        pool_reset   <= 1'b1;
      end else begin
        sha_state    <= sha_state;
        message_head <= message_head;
        nonce_start  <= nonce_start;
        pool_reset   <= pool_reset;
      end
    end
  end

endmodule

// File: tb/tb_shapool_job_loader.sv
// Directed bench for shapool_job_loader with TIMEOUT_CYCLES=16.
// Frame A: bytes 0x00..0x2C. Frame B: bytes 0xFF-i (0xFF..0xD3).
// With SHAPOOL_LOADER_CHECKSUM_EN the trailing checksum (A: 0x2C, B: 0xD3) is appended.
module tb_shapool_job_loader;

  localparam logic [255:0] A_SHA = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  A_MH  = 96'h202122232425262728292a2b;
  localparam logic [7:0]   A_N   = 8'h2c;
  localparam logic [7:0]   A_CK  = 8'h2c;
  localparam logic [255:0] B_SHA = 256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0efeeedecebeae9e8e7e6e5e4e3e2e1e0;
  localparam logic [95:0]  B_MH  = 96'hdfdedddcdbdad9d8d7d6d5d4;
  localparam logic [7:0]   B_N   = 8'hd3;
  localparam logic [7:0]   B_CK  = 8'hd3;
`ifdef SHAPOOL_LOADER_CHECKSUM_EN
  localparam int FLEN = 46;
`else
  localparam int FLEN = 45;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [255:0] sha_state;
  logic [95:0]  message_head;
  logic [7:0]   nonce_start;
  logic         pool_reset;
  logic         job_loaded;
  logic         busy;
  logic         err_timeout;
  logic         err_checksum;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ck_pulses = 0;

  shapool_job_loader #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .sha_state    (sha_state),
    .message_head (message_head),
    .nonce_start  (nonce_start),
    .pool_reset   (pool_reset),
    .job_loaded   (job_loaded),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_checksum (err_checksum)
  );

  always #5 clk = ~clk;

  // Count checksum-error pulses over the whole run.
  always @(posedge clk) begin
    if (err_checksum) ck_pulses <= ck_pulses + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [7:0] frame_byte(input int sel, input int idx);
    logic [7:0] v;
    v = 8'(idx);
    if (sel == 1) v = 8'hff - v;
    return v;
  endfunction

  // Present one byte and return #1 after the edge that transfers it.
  task automatic drive_byte(input logic [7:0] b);
    int guard;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_wait", 256'(guard), 256'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send bytes [first, last) of a frame; rnd inserts random idle gaps and
  // checks that the committed job is held mid-frame.
  task automatic send_range(input int sel, input int first, input int last, input bit rnd,
                            input logic [7:0] ck_mask, input logic [255:0] hold_sha);
    logic [7:0] b;
    for (int i = first; i < last; i++) begin
      if (rnd) begin
        for (int g = 0; g < 3; g++) begin
          if (($urandom & 32'd1) == 32'd0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
      end
      if (i == 45) b = ((sel == 1) ? B_CK : A_CK) ^ ck_mask;
      else         b = frame_byte(sel, i);
      drive_byte(b);
      if (rnd && i < FLEN - 1) begin
        check("t2_busy", 256'(busy), 256'(1));
        check("t2_hold_sha", sha_state, hold_sha);
        check("t2_pool_reset", 256'(pool_reset), 256'(1));
      end
    end
    rx_valid = 1'b0;
  endtask

  // Check the COMMIT cycle and the following cycle of a good frame.
  task automatic expect_commit(input string tag, input logic [255:0] sha, input logic [95:0] mh,
                               input logic [7:0] ns);
    check({tag, "_commit_busy"}, 256'(busy), 256'(1));
    check({tag, "_commit_ready"}, 256'(rx_ready), 256'(0));
    check({tag, "_commit_nojl"}, 256'(job_loaded), 256'(0));
    @(posedge clk);
    #1;
    check({tag, "_job_loaded"}, 256'(job_loaded), 256'(1));
    check({tag, "_pool_reset"}, 256'(pool_reset), 256'(0));
    check({tag, "_sha"}, sha_state, sha);
    check({tag, "_mh"}, 256'(message_head), 256'(mh));
    check({tag, "_ns"}, 256'(nonce_start), 256'(ns));
    @(posedge clk);
    #1;
    check({tag, "_jl_pulse"}, 256'(job_loaded), 256'(0));
    check({tag, "_idle_busy"}, 256'(busy), 256'(0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sha", sha_state, 256'(0));
    check("rst_mh", 256'(message_head), 256'(0));
    check("rst_ns", 256'(nonce_start), 256'(0));
    check("rst_pool_reset", 256'(pool_reset), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_pulses", 256'({job_loaded, err_timeout, err_checksum}), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready_after", 256'(rx_ready), 256'(1));
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    apply_reset();

    // 1: back-to-back frame A.
    send_range(0, 0, 1, 1'b0, 8'h00, 256'(0));
    check("t1_pool_reset_first", 256'(pool_reset), 256'(1));
    send_range(0, 1, FLEN, 1'b0, 8'h00, 256'(0));
    expect_commit("t1", A_SHA, A_MH, A_N);

    // 2: frame B with random valid gaps; frame A must hold until commit.
    send_range(1, 0, FLEN, 1'b1, 8'h00, A_SHA);
    expect_commit("t2", B_SHA, B_MH, B_N);

    // 3: 10 bytes then silence; timeout on the 16th idle edge after byte 9.
    send_range(0, 0, 10, 1'b0, 8'h00, 256'(0));
    idle_cycles(15);
    check("t3_no_early_to", 256'(err_timeout), 256'(0));
    check("t3_busy_before", 256'(busy), 256'(1));
    idle_cycles(1);
    check("t3_err_timeout", 256'(err_timeout), 256'(1));
    check("t3_busy_after", 256'(busy), 256'(0));
    check("t3_pool_reset", 256'(pool_reset), 256'(1));
    check("t3_sha_kept", sha_state, B_SHA);
    idle_cycles(1);
    check("t3_to_pulse", 256'(err_timeout), 256'(0));
    send_range(0, 0, FLEN, 1'b0, 8'h00, 256'(0));
    expect_commit("t3", A_SHA, A_MH, A_N);

    // 4: byte arrives on the cycle the limit is reached.
    send_range(1, 0, 10, 1'b0, 8'h00, 256'(0));
    idle_cycles(15);
    send_range(1, 10, 11, 1'b0, 8'h00, 256'(0));
    check("t4_no_timeout", 256'(err_timeout), 256'(0));
    check("t4_busy", 256'(busy), 256'(1));
    send_range(1, 11, FLEN, 1'b0, 8'h00, 256'(0));
    expect_commit("t4", B_SHA, B_MH, B_N);

`ifdef SHAPOOL_LOADER_CHECKSUM_EN
    // 5: bad checksum is rejected, prior job kept; then a good frame commits.
    send_range(0, 0, FLEN, 1'b0, 8'h01, 256'(0));
    check("t5_err_checksum", 256'(err_checksum), 256'(1));
    @(posedge clk);
    #1;
    check("t5_no_job_loaded", 256'(job_loaded), 256'(0));
    check("t5_pool_reset", 256'(pool_reset), 256'(1));
    check("t5_sha_kept", sha_state, B_SHA);
    check("t5_ck_pulse", 256'(err_checksum), 256'(0));
    send_range(0, 0, FLEN, 1'b0, 8'h00, 256'(0));
    expect_commit("t5", A_SHA, A_MH, A_N);
    check("t5_ck_count", 256'(ck_pulses), 256'(1));
`else
    check("t5_ck_tied", 256'(ck_pulses), 256'(0));
`endif

    // 6: reset after byte 20, then a clean frame B.
    send_range(0, 0, 21, 1'b0, 8'h00, 256'(0));
    apply_reset();
    send_range(1, 0, FLEN, 1'b0, 8'h00, 256'(0));
    expect_commit("t6", B_SHA, B_MH, B_N);
    check("t6_no_timeout", 256'(err_timeout), 256'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
